// File: rtl/inst_fetch_queue_pkg.sv
// ----------------------------------------------------------------------------
// inst_fetch_queue_pkg
// Shared definitions for the instruction fetch queue: bus widths, DEPTH
// limits, the default reset PC, the queue entry layout and a small PC helper.
// ----------------------------------------------------------------------------
package inst_fetch_queue_pkg;

    localparam int IFQ_ADDR_W    = 32;
    localparam int IFQ_DATA_W    = 32;
    localparam int IFQ_ENTRY_W   = IFQ_ADDR_W + IFQ_DATA_W;   // pc + inst

    // Legal range of the DEPTH parameter (power of two only).
    localparam int IFQ_DEPTH_MIN = 2;
    localparam int IFQ_DEPTH_MAX = 16;

    localparam logic [IFQ_ADDR_W-1:0] IFQ_RESET_PC = 32'hbfc0_0000;

    // One queue entry: the fetch address and the instruction returned for it.
    typedef struct packed {
        logic [IFQ_ADDR_W-1:0] pc;
        logic [IFQ_DATA_W-1:0] inst;
    } ifq_entry_t;

    // Sequential fetch address; wraps modulo 2^32.
    function automatic logic [IFQ_ADDR_W-1:0] ifq_next_pc(input logic [IFQ_ADDR_W-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/ifq_fifo.sv
// ----------------------------------------------------------------------------
// ifq_fifo
// Storage for the instruction fetch queue: a DEPTH-entry circular buffer of
// {pc, inst} entries with read/write pointers and an occupancy count.
//
// Ports
//   clk    : clock, rising edge
//   rst    : asynchronous active-low reset
//   push   : write din at the tail
//   pop    : drop the head entry (caller guarantees count > 0)
//   clr    : flush everything; wins over push and pop
//   din    : entry to write
//   dout   : head entry, forced to zero while the buffer is empty
//   count  : number of occupied entries (0..DEPTH)
// ----------------------------------------------------------------------------
module ifq_fifo
    import inst_fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clr,
    input  logic [IFQ_ENTRY_W-1:0]   din,
    output logic [IFQ_ENTRY_W-1:0]   dout,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [IFQ_ENTRY_W-1:0] mem [DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;

    // Pointers are exactly AW bits wide, so a power-of-two DEPTH wraps for free.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
        end
    end

    // NOTE: the entry array has no reset; its contents are only observable
    // through dout, which is masked to zero whenever count is zero.
    always_ff @(posedge clk) begin
        if (push && !clr) mem[wr_ptr] <= din;
    end

    assign dout = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/inst_fetch_queue.sv
// ----------------------------------------------------------------------------
// inst_fetch_queue
// Decouples instruction fetch from decode. Issues sequential fetches to the
// instruction SRAM, buffers each returned {pc, inst} in ifq_fifo and
// presents the head to ID. A redirect (br_e) flushes the queue and restarts
// fetching at br_target on the same edge.
//
// Ports
//   clk, rst            : clock; asynchronous active-low reset
//   stall               : ID frozen, no dequeue
//   br_e, br_target     : redirect pulse and new fetch address
//   mem_stall           : SRAM side refuses the current request
//   inst_sram_*         : fetch request (read-only: wen/wdata tied to 0)
//   inst_sram_rdata     : instruction, one cycle after an accepted request
//   out_valid/pc/inst   : queue head presented to ID
//   count               : occupied entries
// ----------------------------------------------------------------------------
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int                    DEPTH    = 4,
    parameter logic [IFQ_ADDR_W-1:0] RESET_PC = IFQ_RESET_PC
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic                   br_e,
    input  logic [IFQ_ADDR_W-1:0]  br_target,
    input  logic                   mem_stall,
    output logic                   inst_sram_en,
    output logic [3:0]             inst_sram_wen,
    output logic [IFQ_ADDR_W-1:0]  inst_sram_addr,
    output logic [IFQ_DATA_W-1:0]  inst_sram_wdata,
    input  logic [IFQ_DATA_W-1:0]  inst_sram_rdata,
    output logic                   out_valid,
    output logic [IFQ_ADDR_W-1:0]  out_pc,
    output logic [IFQ_DATA_W-1:0]  out_inst,
    output logic [$clog2(DEPTH):0] count
);

    logic [IFQ_ADDR_W-1:0] fetch_pc;
    logic                  pend;     // a response is due this cycle
    logic                  squash;   // the response due this cycle is stale
    logic                  accept;
    logic                  push;
    logic                  pop;
    ifq_entry_t            din;
    ifq_entry_t            dout;

    assign inst_sram_wen   = 4'b0;
    assign inst_sram_wdata = 32'b0;

    // Credit check: an in-flight response already owns a slot, so only issue
    // when occupancy plus that reservation leaves room. Gated by rst so no
    // request leaves while reset is held.
    assign inst_sram_en   = rst && !br_e && ((int'(count) + int'(pend)) < DEPTH);
    assign inst_sram_addr = fetch_pc;
    assign accept         = inst_sram_en && !mem_stall;

    // fetch_pc has already advanced past the request now returning, and it
    // cannot have been redirected without also flushing this response.
    assign din.pc   = fetch_pc - 32'd4;
    assign din.inst = inst_sram_rdata;

    assign push = pend && !squash && !br_e;
    assign pop  = out_valid && !stall && !br_e;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            pend     <= 1'b0;
            squash   <= 1'b0;
        end else begin
            if (br_e)        fetch_pc <= br_target;
            else if (accept) fetch_pc <= ifq_next_pc(fetch_pc);
            pend   <= accept;
            // Issue is blocked during a redirect, so this only guards against
            // a response ever landing after the flush that invalidated it.
            squash <= br_e && accept;
        end
    end

    ifq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .clr   (br_e),
        .din   (din),
        .dout  (dout),
        .count (count)
    );

    assign out_valid = (count != '0);
    assign out_pc    = dout.pc;
    assign out_inst  = dout.inst;

endmodule

// File: tb/tb_inst_fetch_queue.sv
module tb_inst_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam int          CW       = $clog2(DEPTH) + 1;
    localparam logic [31:0] RESET_PC = 32'hbfc0_0000;

    logic          clk;
    logic          rst;
    logic          stall;
    logic          br_e;
    logic [31:0]   br_target;
    logic          mem_stall;
    logic          inst_sram_en;
    logic [3:0]    inst_sram_wen;
    logic [31:0]   inst_sram_addr;
    logic [31:0]   inst_sram_wdata;
    logic [31:0]   inst_sram_rdata;
    logic          out_valid;
    logic [31:0]   out_pc;
    logic [31:0]   out_inst;
    logic [CW-1:0] count;

    inst_fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .br_e            (br_e),
        .br_target       (br_target),
        .mem_stall       (mem_stall),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_wen   (inst_sram_wen),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata),
        .inst_sram_rdata (inst_sram_rdata),
        .out_valid       (out_valid),
        .out_pc          (out_pc),
        .out_inst        (out_inst),
        .count           (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the queue contents as a list of {pc, inst}, the next
    // fetch address, and the one response that may be in flight.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_pc;
    bit          m_pend;
    logic [31:0] m_pend_pc;

    int errors = 0;
    int checks = 0;

    // Instruction memory contents: a fixed function of the address.
    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return {pc[15:0], ~pc[31:16]} ^ 32'h1357_9bdf;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_pc      = RESET_PC;
        m_pend    = 1'b0;
        m_pend_pc = '0;
    endtask

    // One clock cycle: drive at negedge, compare against the model, then let
    // the rising edge happen and advance the model by the same rules.
    task automatic step(input bit st, input bit br, input logic [31:0] tgt, input bit ms);
        bit    exp_en;
        bit    acc;
        ent_t  e;
        @(negedge clk);
        stall           = st;
        br_e            = br;
        br_target       = tgt;
        mem_stall       = ms;
        inst_sram_rdata = m_pend ? inst_of(m_pend_pc) : $urandom;
        #1;
        exp_en = !br && ((q.size() + int'(m_pend)) < DEPTH);
        check("en",    32'(inst_sram_en), 32'(exp_en));
        check("addr",  inst_sram_addr, m_pc);
        check("count", 32'(count), 32'(q.size()));
        check("valid", 32'(out_valid), 32'(q.size() > 0));
        if (q.size() > 0) begin
            check("out_pc",   out_pc,   q[0].pc);
            check("out_inst", out_inst, q[0].inst);
        end
        @(posedge clk);
        acc = exp_en && !ms;
        if (br) begin
            q.delete();
            m_pc   = tgt;
            m_pend = 1'b0;
        end else begin
            if (!st && q.size() > 0) void'(q.pop_front());
            if (m_pend) begin
                e.pc   = m_pend_pc;
                e.inst = inst_of(m_pend_pc);
                q.push_back(e);
            end
            m_pend = acc;
            if (acc) begin
                m_pend_pc = m_pc;
                m_pc      = m_pc + 32'd4;
            end
        end
    endtask

    initial begin
        int n;
        rst             = 1'b0;
        stall           = 1'b0;
        br_e            = 1'b0;
        br_target       = '0;
        mem_stall       = 1'b0;
        inst_sram_rdata = '0;
        model_reset();

        // Held in reset: everything quiet and zero.
        #12;
        check("rst_en",    32'(inst_sram_en), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_pc",    out_pc, 32'd0);
        check("rst_inst",  out_inst, 32'd0);
        check("rst_wen",   32'(inst_sram_wen), 32'd0);
        check("rst_wdata", inst_sram_wdata, 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;

        // Free-running fetch from RESET_PC, one address per cycle.
        repeat (8) step(0, 0, '0, 0);

        // Long stall: queue fills to DEPTH and issue stops.
        repeat (10) step(1, 0, '0, 0);
        #1;
        check("sat_count", 32'(count), DEPTH);
        check("sat_en",    32'(inst_sram_en), 32'd0);
        repeat (8) step(0, 0, '0, 0);

        // Redirect with count=3 and a response in flight.
        n = 0;
        while (!(q.size() == 3 && m_pend) && n < 20) begin
            step(1, 0, '0, 0);
            n++;
        end
        check("br_setup", 32'(q.size() == 3 && m_pend), 32'd1);
        step(0, 1, 32'hbfc0_0100, 0);
        #1;
        check("br_valid", 32'(out_valid), 32'd0);
        check("br_addr",  inst_sram_addr, 32'hbfc0_0100);
        repeat (6) step(0, 0, '0, 0);

        // mem_stall held at 0xbfc00008.
        step(0, 1, RESET_PC, 0);
        n = 0;
        while (m_pc != 32'hbfc0_0008 && n < 10) begin
            step(0, 0, '0, 0);
            n++;
        end
        check("ms_setup", m_pc, 32'hbfc0_0008);
        repeat (5) step(0, 0, '0, 1);
        #1;
        check("ms_hold", inst_sram_addr, 32'hbfc0_0008);
        repeat (4) step(0, 0, '0, 0);

        // Redirect and mem_stall together.
        step(0, 1, 32'h8000_0040, 1);
        #1;
        check("brms_addr",  inst_sram_addr, 32'h8000_0040);
        check("brms_count", 32'(count), 32'd0);
        repeat (4) step(0, 0, '0, 0);

        // Asynchronous reset mid-stream with two entries queued.
        n = 0;
        while (q.size() != 2 && n < 10) begin
            step(1, 0, '0, 0);
            n++;
        end
        check("arst_setup", 32'(q.size()), 32'd2);
        #3 rst = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_count", 32'(count), 32'd0);
        check("arst_en",    32'(inst_sram_en), 32'd0);
        check("arst_pc",    out_pc, 32'd0);
        check("arst_inst",  out_inst, 32'd0);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        step(0, 0, '0, 0);
        repeat (4) step(0, 0, '0, 0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) < 3,
                 $urandom_range(0, 19) == 0,
                 $urandom & 32'hffff_fffc,
                 $urandom_range(0, 3) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
